uart_tx_frame_sender: RTL and testbench

- UART transmitter. Accepts one parallel word from an upstream sensor over a valid/ready handshake.
- Serializes the word onto a single line as an 8N1-style frame: one start bit, DATA_WIDTH data bits LSB-first, one stop bit, no parity.
- Sits between a sensor data source and the board's UART TX pin. The line is carried on the shared uart_if interface (signal sig).

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_if.sv | 9 +
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_tx_frame_sender.sv | 105 ++++++++++
 tb/tb_uart_tx_frame_sender.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and bit-period arithmetic.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    // Integer truncation is intended; the residual rate error is the caller's concern.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_if.sv
// Single-wire UART line shared between the TX and RX sides of the board.
interface uart_if #(
    parameter int DATA_WIDTH = 8
);
    logic sig;

    modport tx (output sig);
    modport rx (input sig);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses bit_done on the last cycle of every CLKS_PER_BIT-cycle bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_done
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        bit_done = en && (cnt_q == LAST);
        cnt_d    = cnt_q + CNT_W'(1);
        if (!en || bit_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_tx_frame_sender.sv
// UART transmitter: takes one word over valid/ready and sends it as start, LSB-first data, stop.
module uart_tx_frame_sender
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_from_sensor,
    input  logic                  valid_from_sensor,
    output logic                  ready_to_sensor,
    uart_if.tx                    txif
);
    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_rate
            $error("uart_tx_frame_sender: CLK_FREQ/BAUD_RATE must be at least 2");
        end
    endgenerate

    uart_tx_state_t        state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  sig_q, sig_d;
    logic                  ready_q, ready_d;
    logic                  bit_done;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q != IDLE),
        .bit_done (bit_done)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (valid_from_sensor && ready_q) begin
                    state_d = START;
                    shreg_d = data_from_sensor;
                    idx_d   = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the line flops switch on the bit boundary itself.
        sig_d = 1'b1;
        case (state_d)
            START:   sig_d = 1'b0;
            DATA:    sig_d = shreg_d[0];
            default: sig_d = 1'b1;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            sig_q   <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            sig_q   <= sig_d;
            ready_q <= ready_d;
        end
    end

    assign txif.sig        = sig_q;
    assign ready_to_sensor = ready_q;
endmodule

// File: tb/tb_uart_tx_frame_sender.sv
// Bench for uart_tx_frame_sender: frame-level reference model plus directed and random traffic.
module tb_uart_tx_frame_sender;
    localparam int N      = 100_000_000 / 115_200;
    localparam int N_SLOW = 100_000_000 / 9_600;
    localparam int FRAME  = 10 * N;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic [7:0] data2;
    logic       valid2;
    logic       ready2;

    int checks = 0;
    int errors = 0;

    uart_if #(.DATA_WIDTH(8)) txif  ();
    uart_if #(.DATA_WIDTH(8)) txif2 ();

    uart_tx_frame_sender #(
        .DATA_WIDTH (8),
        .BAUD_RATE  (115200),
        .CLK_FREQ   (100_000_000)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .data_from_sensor  (data),
        .valid_from_sensor (valid),
        .ready_to_sensor   (ready),
        .txif              (txif)
    );

    uart_tx_frame_sender #(
        .DATA_WIDTH (8),
        .BAUD_RATE  (9600),
        .CLK_FREQ   (100_000_000)
    ) u_dut_slow (
        .clk               (clk),
        .rst               (rst),
        .data_from_sensor  (data2),
        .valid_from_sensor (valid2),
        .ready_to_sensor   (ready2),
        .txif              (txif2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a frame is just a start time and a word; line level follows from elapsed cycles.
    logic       m_busy = 1'b0;
    int         m_pos = 0;
    int         m_idle = 0;
    logic [7:0] m_word = '0;
    logic       mon_en = 1'b0;
    int         dut_frames = 0;
    logic       prev_ready = 1'b1;
    int         run2 = 0;
    int         first2 = 0;

    always @(posedge clk) begin
        logic was_busy;
        was_busy = m_busy;
        if (rst) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (valid) begin
                m_busy = 1'b1;
                m_pos  = 0;
                m_word = data;
            end
        end else begin
            m_pos++;
            if (m_pos == FRAME) m_busy = 1'b0;
        end
        if (!m_busy) m_idle = was_busy ? 0 : m_idle + 1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (m_busy) begin
                int b;
                int r;
                logic e;
                b = m_pos / N;
                r = m_pos % N;
                e = (b == 0) ? 1'b0 : (b <= 8) ? m_word[b-1] : 1'b1;
                if (r == 0 || r == N / 2 || r == N - 1) begin
                    check("frame_sig", txif.sig, e);
                    check("frame_ready", ready, 0);
                end
            end else if (m_idle == 0 || m_idle % 64 == 0) begin
                check("idle_sig", txif.sig, 1);
                check("idle_ready", ready, 1);
            end
            if (prev_ready === 1'b1 && ready === 1'b0) dut_frames++;
            prev_ready = ready;
            if (!rst) begin
                if (txif2.sig === 1'b0) run2++;
                else begin
                    if (run2 != 0 && first2 == 0) first2 = run2;
                    run2 = 0;
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_hold(input string tag, input int n);
        int bad;
        bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (txif.sig !== 1'b1 || ready !== 1'b1) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic wait_ready(input string tag, input logic lvl, input int limit);
        int t;
        t = 0;
        while (ready !== lvl && t < limit) begin
            @(negedge clk);
            t++;
        end
        check(tag, ready, lvl);
    endtask

    initial begin
        int t;
        int w;
        int f0;
        rst    = 1'b1;
        valid  = 1'b0;
        data   = '0;
        valid2 = 1'b0;
        data2  = 8'h01;
        @(negedge clk);
        mon_en = 1'b1;
        wait_cyc(2 * N);
        check("reset_sig", txif.sig, 1);
        check("reset_ready", ready, 1);
        rst    = 1'b0;
        valid2 = 1'b1;

        // No valid: line must sit idle.
        idle_hold("idle_no_valid", 5 * N);

        // Two back-to-back A5 frames; measure start-bit width on the way.
        f0    = dut_frames;
        data  = 8'hA5;
        valid = 1'b1;
        t = 0;
        while (txif.sig !== 1'b0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("start_seen", txif.sig, 0);
        w = 0;
        while (txif.sig === 1'b0 && w < 3 * N) begin
            @(negedge clk);
            w++;
        end
        check("start_width_115200", w, 100_000_000 / 115_200);
        wait_cyc(20 * N - w - t);
        valid = 1'b0;
        wait_ready("a5_done", 1'b1, 12 * N);
        check("a5_frame_count", dut_frames - f0, 2);
        idle_hold("idle_after_a5", 8);

        // 5A with valid dropped and data changed mid-frame; then re-assert with a random word.
        data  = 8'h5A;
        valid = 1'b1;
        wait_cyc(3 * N);
        data = 8'hFF;
        wait_cyc(2 * N);
        valid = 1'b0;
        wait_ready("5a_done", 1'b1, 12 * N);
        idle_hold("idle_after_5a", 3 * N);
        data  = 8'($urandom);
        valid = 1'b1;
        wait_ready("reaccept", 1'b0, 4);
        valid = 1'b0;
        wait_ready("reaccept_done", 1'b1, 12 * N);

        // Reset in data bit 3, with a word offered during reset.
        data  = 8'($urandom);
        valid = 1'b1;
        wait_ready("pre_reset_accept", 1'b0, 4);
        valid = 1'b0;
        wait_cyc(4 * N + N / 2);
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'($urandom);
        @(negedge clk);
        check("abort_sig", txif.sig, 1);
        check("abort_ready", ready, 1);
        @(negedge clk);
        rst   = 1'b0;
        valid = 1'b0;
        idle_hold("idle_after_abort", 3 * N);

        // Random words with random valid lengths.
        for (int i = 0; i < 3; i++) begin
            data  = 8'($urandom);
            valid = 1'b1;
            wait_cyc($urandom_range(1, 2 * N));
            valid = 1'b0;
            data  = 8'($urandom);
            wait_ready("rand_done", 1'b1, 12 * N);
            wait_cyc($urandom_range(0, 5));
        end

        check("start_width_9600", first2, 100_000_000 / 9_600);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
